// File: rtl/mem_arb_pkg.sv
// Shared types for the I-cache / D-side memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_D_XFER  = 2'd1,
    ARB_I_BURST = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between data and I-refill requesters.
// Optional ARB_RR_EN selects round-robin on collision instead of fixed D priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  grant_t last_gnt,
`endif
  input  logic   d_req,
  input  logic   i_req,
  output logic   gnt_valid_c,
  output grant_t gnt_c
);

  always_comb begin
    gnt_valid_c = d_req | i_req;
    gnt_c       = GNT_D;
    if (d_req && i_req) begin
`ifdef ARB_RR_EN
      gnt_c = (last_gnt == GNT_D) ? GNT_I : GNT_D;
`else
      gnt_c = GNT_D;
`endif
    end else if (i_req) begin
      gnt_c = GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one backing memory between single-word data accesses and I-cache line refills.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINE_WORDS    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_req,
  input  logic [ADDRESS_WIDTH-1:0]         i_addr,
  output logic                             i_rvalid,
  output logic [DATA_WIDTH-1:0]            i_rdata,
  output logic [$clog2(LINE_WORDS)-1:0]    i_beat,
  output logic                             i_done,
  input  logic                             d_req,
  input  logic                             d_we,
  input  logic [ADDRESS_WIDTH-1:0]         d_addr,
  input  logic [DATA_WIDTH-1:0]            d_wdata,
  output logic [DATA_WIDTH-1:0]            d_rdata,
  output logic                             d_ack,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDRESS_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ready,
  output logic                             busy
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = BEAT_W + 2;
  localparam int unsigned HI_W   = ADDRESS_WIDTH - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  arb_state_t        state;
  logic [BEAT_W-1:0] beat;
  logic [HI_W-1:0]   line_hi;
  logic              d_pend_c;
  logic              i_pend_c;
  logic              gnt_valid_c;
  grant_t            gnt_c;

  // Line offset bits of the refill address are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, i_addr[OFF_W-1:0]};

  // Requesters still hold their request during the ack/done cycle; do not re-grant it.
  assign d_pend_c = d_req & ~d_ack & ~i_done;
  assign i_pend_c = i_req & ~d_ack & ~i_done;

`ifdef ARB_RR_EN
  grant_t last_gnt;
`endif

  mem_arb_pick u_pick (
`ifdef ARB_RR_EN
    .last_gnt    (last_gnt),
`endif
    .d_req       (d_pend_c),
    .i_req       (i_pend_c),
    .gnt_valid_c (gnt_valid_c),
    .gnt_c       (gnt_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      beat      <= '0;
      line_hi   <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      i_beat    <= '0;
      i_done    <= 1'b0;
`ifdef ARB_RR_EN
      last_gnt  <= GNT_I;
`endif
    end else begin
      d_ack    <= 1'b0;
      i_rvalid <= 1'b0;
      i_done   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gnt_valid_c) begin
            busy    <= 1'b1;
            mem_req <= 1'b1;
            beat    <= '0;
`ifdef ARB_RR_EN
            last_gnt <= gnt_c;
`endif
            if (gnt_c == GNT_D) begin
              state     <= ARB_D_XFER;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state    <= ARB_I_BURST;
              mem_we   <= 1'b0;
              line_hi  <= i_addr[ADDRESS_WIDTH-1:OFF_W];
              mem_addr <= {i_addr[ADDRESS_WIDTH-1:OFF_W], OFF_W'(0)};
            end
          end
        end
        ARB_D_XFER: begin
          if (mem_ready) begin
            state   <= ARB_IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_ack   <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        ARB_I_BURST: begin
          if (mem_ready) begin
            i_rvalid <= 1'b1;
            i_rdata  <= mem_rdata;
            i_beat   <= beat;
            if (beat == LAST_BEAT) begin
              state   <= ARB_IDLE;
              busy    <= 1'b0;
              mem_req <= 1'b0;
              beat    <= '0;
              i_done  <= 1'b1;
            end else begin
              beat     <= BEAT_W'(beat + 1'b1);
              mem_addr <= {line_hi, BEAT_W'(beat + 1'b1), 2'b00};
            end
          end
        end
        default: begin
          state   <= ARB_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (default build or ARB_RR_EN).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [1:0]  i_beat;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [1:0]  beat;
    logic [31:0] data;
    logic        done;
  } i_exp_t;

  mem_exp_t    mq[$];
  i_exp_t      iq[$];
  logic [31:0] dq[$];
  logic [31:0] last_rd;
  logic        d_drop;
  logic        i_drop;
  int          tests;
  int          fails;

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_beat(i_beat), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ 32'h5A5A_0000) + 32'h1;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory-side scoreboard before the edge, requester-side after it.
  task automatic cycle(input logic rdy);
    mem_exp_t me;
    i_exp_t   ie;
    logic [31:0] de;
    mem_ready = rdy;
    if (mem_req && rdy) begin
      chk("mem_beat_expected", 64'(mq.size() > 0), 64'd1);
      if (mq.size() > 0) begin
        me = mq.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(me.addr));
        chk("mem_we", 64'(mem_we), 64'(me.we));
        if (me.we) chk("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
      end
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    if (d_drop) begin d_req = 1'b0; d_drop = 1'b0; end
    if (i_drop) begin i_req = 1'b0; i_drop = 1'b0; end
    if (d_ack) begin
      chk("d_ack_expected", 64'(dq.size() > 0), 64'd1);
      if (dq.size() > 0) begin
        de = dq.pop_front();
        chk("d_rdata", 64'(d_rdata), 64'(de));
      end
      d_drop = 1'b1;
    end
    if (i_rvalid) begin
      chk("i_rvalid_expected", 64'(iq.size() > 0), 64'd1);
      if (iq.size() > 0) begin
        ie = iq.pop_front();
        chk("i_beat", 64'(i_beat), 64'(ie.beat));
        chk("i_rdata", 64'(i_rdata), 64'(ie.data));
        chk("i_done", 64'(i_done), 64'(ie.done));
      end
      if (i_done) i_drop = 1'b1;
    end else if (i_done) begin
      chk("i_done_without_rvalid", 64'(i_rvalid), 64'd1);
    end
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    mq.push_back('{a, we, wd});
    if (!we) last_rd = mem_word(a);
    dq.push_back(last_rd);
  endtask

  task automatic push_beats(input logic [31:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      mq.push_back('{base + 32'(4 * b), 1'b0, 32'h0});
      iq.push_back('{2'(b), mem_word(base + 32'(4 * b)), (b == 3)});
    end
  endtask

  task automatic issue_i(input logic [31:0] a);
    i_req = 1'b1; i_addr = a;
    push_beats({a[31:4], 4'h0}, 4);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((busy || d_req || i_req) && n < max) begin
      cycle(1'b1);
      n++;
    end
    chk("drain_bound", 64'(n < max), 64'd1);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0;
    d_drop = 1'b0; i_drop = 1'b0; last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_d_ack", 64'(d_ack), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);
    chk("rst_i_rvalid", 64'(i_rvalid), 64'd0);
    chk("rst_i_done", 64'(i_done), 64'd0);
    rst = 1'b0;
    cycle(1'b0);

    // Minimum-latency data read.
    issue_d(1'b0, 32'h100, 32'h0);
    cycle(1'b0);
    chk("rd_mem_req", 64'(mem_req), 64'd1);
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_mem_we", 64'(mem_we), 64'd0);
    chk("rd_no_early_ack", 64'(d_ack), 64'd0);
    cycle(1'b1);
    chk("rd_ack_latency", 64'(d_ack), 64'd1);
    cycle(1'b0);
    chk("rd_ack_pulse", 64'(d_ack), 64'd0);
    chk("rd_idle", 64'(busy), 64'd0);
    cycle(1'b0);

    // Line refill with unaligned request address.
    issue_i(32'h20C);
    cycle(1'b0);
    chk("burst_base", 64'(mem_addr), 64'h200);
    chk("burst_mem_we", 64'(mem_we), 64'd0);
    drain(20);

    // First collision: D granted in either mode (last grant was I).
    issue_d(1'b0, 32'h300, 32'h0);
    issue_i(32'h400);
    drain(40);

    // Data read stalled by memory for 10 cycles.
    issue_d(1'b0, 32'h600, 32'h0);
    cycle(1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0);
      chk("stall_mem_req", 64'(mem_req), 64'd1);
      chk("stall_mem_addr", 64'(mem_addr), 64'h600);
      chk("stall_no_ack", 64'(d_ack), 64'd0);
    end
    drain(10);

    // Second collision: round-robin now favours I, fixed priority still D.
`ifdef ARB_RR_EN
    issue_i(32'h440);
    issue_d(1'b0, 32'h340, 32'h0);
`else
    issue_d(1'b0, 32'h340, 32'h0);
    issue_i(32'h440);
`endif
    drain(40);

    // Write raised mid-burst waits for the line to finish.
    issue_i(32'h500);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    issue_d(1'b1, 32'h40, 32'h55);
    drain(40);

    // Reset during beat 2 aborts the burst without i_done.
    i_req = 1'b1; i_addr = 32'h700;
    push_beats(32'h700, 2);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    rst = 1'b1;
    cycle(1'b0);
    chk("abort_mem_req", 64'(mem_req), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_i_done", 64'(i_done), 64'd0);
    chk("abort_i_rvalid", 64'(i_rvalid), 64'd0);
    chk("abort_d_rdata", 64'(d_rdata), 64'd0);
    rst = 1'b0; i_req = 1'b0; i_drop = 1'b0; last_rd = '0;
    cycle(1'b1);
    chk("abort_stays_idle", 64'(busy), 64'd0);
    issue_i(32'h704);
    drain(20);

    chk("mem_queue_empty", 64'(mq.size()), 64'd0);
    chk("d_queue_empty", 64'(dq.size()), 64'd0);
    chk("i_queue_empty", 64'(iq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Param DATA_WIDTH, 32, word width of all data buses.
REQ-002 Param ADDRESS_WIDTH, 32, byte address width.
REQ-003 Param LINE_WORDS, 4, words per I-cache refill line; power of two, >=2.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 i_req  in  1  I-cache refill request; held high until i_done.
REQ-007 i_addr  in  ADDRESS_WIDTH  refill address; low log2(LINE_WORDS)+2 bits ignored.
REQ-008 i_rvalid  out  1  one refill word valid this cycle.
REQ-009 i_rdata  out  DATA_WIDTH  refill word.
REQ-010 i_beat  out  log2(LINE_WORDS)  word index of i_rdata within line.
REQ-011 i_done  out  1  one-cycle pulse with final i_rvalid.
REQ-012 d_req  in  1  data access request; held high until d_ack.
REQ-013 d_we  in  1  1 = write, 0 = read.
REQ-014 d_addr  in  ADDRESS_WIDTH  word-aligned data address.
REQ-015 d_wdata  in  DATA_WIDTH  write data.
REQ-016 d_rdata  out  DATA_WIDTH  read data, valid with d_ack.
REQ-017 d_ack  out  1  one-cycle completion pulse.
REQ-018 mem_req  out  1  backing-memory access active.
REQ-019 mem_we  out  1  backing-memory write strobe.
REQ-020 mem_addr  out  ADDRESS_WIDTH  backing-memory byte address.
REQ-021 mem_wdata  out  DATA_WIDTH  backing-memory write data.
REQ-022 mem_rdata  in  DATA_WIDTH  backing-memory read data, valid with mem_ready.
REQ-023 mem_ready  in  1  current word accepted/returned this cycle.
REQ-024 busy  out  1  high whenever state != IDLE.

Function
REQ-025 FSM states IDLE, D_XFER, I_BURST; transitions only as stated below.
REQ-026 IDLE: grant per REQ-035/036, latch request fields at grant edge; go D_XFER or I_BURST; beat counter cleared to 0.
REQ-027 IDLE ignores d_req and i_req in any cycle where d_ack or i_done is high (requester drop cycle).
REQ-028 mem_req high in every D_XFER/I_BURST cycle, low in IDLE; first mem_req cycle = cycle after grant edge.
REQ-029 D_XFER: mem_addr = latched d_addr, mem_we = latched d_we, mem_wdata = latched d_wdata; on mem_ready go IDLE.
REQ-030 d_ack and d_rdata registered: asserted cycle after mem_ready; d_rdata = captured mem_rdata on read, held otherwise.
REQ-031 I_BURST: mem_we = 0; mem_addr = aligned line base + beat*4; each mem_ready increments beat.
REQ-032 i_rvalid, i_rdata, i_beat registered: cycle after each mem_ready; i_beat = beat just completed.
REQ-033 beat LINE_WORDS-1 completing: go IDLE, beat wraps to 0, i_done pulses with that i_rvalid.
REQ-034 Burst non-preemptible; d_req arriving during I_BURST waits until IDLE; no mem_ready = indefinite wait, no timeout.
REQ-035 Arbitration default: d_req has fixed priority over i_req when both high in IDLE.
REQ-036 Single pending requester always granted from IDLE regardless of arbitration mode.
REQ-037 Minimum D read latency: d_req sampled cycle 0, mem_ready cycle 1, d_ack cycle 2.

Reset
REQ-038 rst high at posedge: state IDLE, beat 0, all outputs 0, last-grant = I; takes effect mid-transfer.
REQ-039 Transfer aborted by rst produces no d_ack/i_done; requester re-issues after rst low.

Configuration
REQ-040 ARB_RR_EN defined: round-robin; when both pending, grant the side not last granted; last-grant updated at each grant.
REQ-041 ARB_RR_EN undefined: fixed D priority per REQ-035; no last-grant state is built.

Structure
REQ-042 Package mem_arb_pkg holds arb_state_t enum (ARB_IDLE, ARB_D_XFER, ARB_I_BURST) and grant_t enum (GNT_D, GNT_I).
REQ-043 Sub-module mem_arb_pick: combinational grant selection from d_req, i_req, last-grant; FSM, datapath, counter stay in mem_arbiter.

Verification
REQ-044 d_req read 0x100, mem_ready 1 cycle later, mem_rdata 0xDEADBEEF -> d_ack cycle 2, d_rdata 0xDEADBEEF, mem_we 0.
REQ-045 i_req addr 0x20C, mem_ready every cycle -> mem_addr 0x200,0x204,0x208,0x20C; i_beat 0..3; i_done with beat 3.
REQ-046 d_req and i_req same cycle, default build -> D granted first, burst starts after d_ack; with ARB_RR_EN, second collision grants I.
REQ-047 d_req write 0x40=0x55 raised mid-burst -> no mem_we during burst; write issued after i_done, d_ack once.
REQ-048 rst high during beat 2 of burst -> next cycle IDLE, mem_req 0, busy 0, no i_done.
REQ-049 mem_ready held low 10 cycles in D_XFER -> mem_req/mem_addr stable, no d_ack until ready.
